// File: rtl/mcl_fxd_pipe_host.sv
// Host driver/collector for the MCL sine pipeline: sweeps operands out on the x port,
// captures results with their sequence index into a credit-protected FIFO.
module mcl_fxd_pipe_host #(
    parameter int FLT_EXP    = 11,
    parameter int FLT_FRAC   = 52,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_start,
    input  logic [FLT_EXP+FLT_FRAC:0]   cfg_x_start,
    input  logic [FLT_EXP+FLT_FRAC:0]   cfg_x_step,
    input  logic [CNT_W-1:0]            cfg_count,
    output logic                        busy,
    output logic                        done,
    output logic                        mcl_avail_x,
    input  logic                        mcl_get_x,
    output logic [FLT_EXP+FLT_FRAC:0]   mcl_data_x,
    input  logic                        mcl_avail,
    output logic                        mcl_get,
    input  logic [FLT_EXP+FLT_FRAC:0]   mcl_data,
    output logic                        res_avail,
    input  logic                        res_get,
    output logic [FLT_EXP+FLT_FRAC:0]   res_data,
    output logic [CNT_W-1:0]            res_idx
);
    localparam int W  = FLT_EXP + FLT_FRAC + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    // All ports: a word moves on a rising edge where avail && get; the producer
    // holds avail and data steady until that edge.

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [W-1:0]     x_cur, x_step_q;
    logic [CNT_W-1:0] count_q, issued, received, in_flight;
    logic [W-1:0]     mem_data [FIFO_DEPTH];
    logic [CNT_W-1:0] mem_idx  [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fifo_cnt;
    logic             fifo_full, fifo_empty, push, pop, x_fire, start_fire, credit_ok;

    assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = mcl_avail && mcl_get;
    assign pop        = res_get && !fifo_empty;
    assign start_fire = (state == IDLE) && cfg_start;
    assign x_fire     = mcl_avail_x && mcl_get_x;

    // Every outstanding operand owns a FIFO slot, so results can never overflow it.
    assign in_flight = issued - received;
    assign credit_ok = ({1'b0, in_flight} + (CNT_W+1)'(fifo_cnt)) < (CNT_W+1)'(FIFO_DEPTH);

    always_comb begin
        state_nx    = state;
        mcl_avail_x = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) state_nx = (cfg_count != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
                mcl_avail_x = credit_ok;
                if (credit_ok && mcl_get_x && (issued + CNT_W'(1) == count_q)) state_nx = DRAIN;
            end
            DRAIN: begin
                if ((received == count_q) && fifo_empty) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x_cur    <= '0;
            x_step_q <= '0;
            count_q  <= '0;
            issued   <= '0;
            received <= '0;
        end else begin
            state <= state_nx;
            if (start_fire) begin
                x_cur    <= cfg_x_start;
                x_step_q <= cfg_x_step;
                count_q  <= cfg_count;
                issued   <= '0;
            end else if (x_fire) begin
                x_cur  <= x_cur + x_step_q;
                issued <= issued + CNT_W'(1);
            end
            // Strays captured in IDLE still take an index; a new sweep restarts at 0.
            if (start_fire)  received <= '0;
            else if (push)   received <= received + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_idx[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= mcl_data;
                mem_idx[wr_ptr]  <= received;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign mcl_data_x = x_cur;
    assign mcl_get    = !fifo_full;
    assign res_avail  = !fifo_empty;
    assign res_data   = mem_data[rd_ptr];
    assign res_idx    = mem_idx[rd_ptr];
endmodule

// File: tb/tb_mcl_fxd_pipe_host.sv
// Bench for mcl_fxd_pipe_host: echo-pipeline model, expected-result queues filled from
// the sweep definition, and a monitor that pops and compares on every transfer.
module tb_mcl_fxd_pipe_host;
    localparam int W     = 64;
    localparam int CNT_W = 16;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cfg_start = 1'b0;
    logic [W-1:0]     cfg_x_start = '0, cfg_x_step = '0;
    logic [CNT_W-1:0] cfg_count = '0;
    logic             busy, done, mcl_avail_x, mcl_get, res_avail;
    logic             mcl_get_x, mcl_avail, res_get;
    logic [W-1:0]     mcl_data_x, mcl_data, res_data;
    logic [CNT_W-1:0] res_idx;

    always #5 clk = ~clk;

    mcl_fxd_pipe_host #(.FLT_EXP(11), .FLT_FRAC(52), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_x_start(cfg_x_start),
        .cfg_x_step(cfg_x_step), .cfg_count(cfg_count), .busy(busy), .done(done),
        .mcl_avail_x(mcl_avail_x), .mcl_get_x(mcl_get_x), .mcl_data_x(mcl_data_x),
        .mcl_avail(mcl_avail), .mcl_get(mcl_get), .mcl_data(mcl_data),
        .res_avail(res_avail), .res_get(res_get), .res_data(res_data), .res_idx(res_idx)
    );

    int total = 0;
    int bad   = 0;
    logic [W+CNT_W-1:0] exp_q[$];
    logic [W-1:0]       iss_q[$];
    logic [W-1:0]       pipe_q[$];
    int                 pipe_t[$];
    int cyc = 0, x_cnt = 0, done_cnt = 0;
    int get_x_mode = 0, res_mode = 0;

    task automatic check(input string name, input logic [W+CNT_W-1:0] act, input logic [W+CNT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pipeline model: identity function, result offered three cycles after acceptance.
    initial begin : pipe_model
        bit xf, rf;
        logic [W-1:0] xd;
        mcl_avail = 1'b0; mcl_data = '0; mcl_get_x = 1'b0; res_get = 1'b0;
        forever begin
            @(negedge clk);
            xf = mcl_avail_x && mcl_get_x;
            xd = mcl_data_x;
            rf = mcl_avail && mcl_get;
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                pipe_q.delete();
                pipe_t.delete();
            end else begin
                if (rf) begin
                    void'(pipe_q.pop_front());
                    void'(pipe_t.pop_front());
                end
                if (xf) begin
                    pipe_q.push_back(xd);
                    pipe_t.push_back(cyc + 3);
                end
            end
            #1;
            mcl_avail = (pipe_q.size() > 0) && (pipe_t[0] <= cyc);
            mcl_data  = (pipe_q.size() > 0) ? pipe_q[0] : '0;
            case (get_x_mode)
                0:       mcl_get_x = 1'b1;
                1:       mcl_get_x = !mcl_get_x;
                default: mcl_get_x = 1'($urandom_range(0, 1));
            endcase
            case (res_mode)
                0:       res_get = 1'b1;
                1:       res_get = 1'b0;
                default: res_get = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares every operand and result transfer against the expected queues.
    initial begin : monitor
        bit prev_stall = 1'b0, prev_done = 1'b0;
        logic [W-1:0] prev_x = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (res_avail && res_get) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL res_extra: got %0h/%0d expected none", res_data, res_idx);
                    end else check("result", {res_data, res_idx}, exp_q.pop_front());
                end
                if (mcl_avail_x && mcl_get_x) begin
                    x_cnt++;
                    if (iss_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL operand_extra: got %0h expected none", mcl_data_x);
                    end else check("operand", mcl_data_x, iss_q.pop_front());
                end
                if (prev_stall) begin
                    check("stall_avail_held", mcl_avail_x, 1);
                    check("stall_data_held", mcl_data_x, prev_x);
                end
                prev_stall = mcl_avail_x && !mcl_get_x;
                prev_x     = mcl_data_x;
                if (done) begin
                    done_cnt++;
                    if (prev_done) begin
                        total++; bad++;
                        $display("FAIL done_width: got 2+ cycles expected 1");
                    end
                end
                prev_done = done;
            end else begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end
        end
    end

    task automatic start(input logic [W-1:0] xs, input logic [W-1:0] st, input int cnt, input bit push_exp);
        cfg_x_start = xs;
        cfg_x_step  = st;
        cfg_count   = CNT_W'(cnt);
        cfg_start   = 1'b1;
        if (push_exp) begin
            for (int i = 0; i < cnt; i++) begin
                logic [W-1:0] op;
                op = xs + st * W'(i);
                iss_q.push_back(op);
                exp_q.push_back({op, CNT_W'(i)});
            end
        end
        tick(1);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick(1);
            n++;
        end
        total++;
        if (done_cnt == d0) begin
            bad++;
            $display("FAIL %s_done: got no done in %0d cycles expected a pulse", name, budget);
        end
        tick(2);
        check({name, "_busy"}, busy, 0);
        check({name, "_results_left"}, exp_q.size(), 0);
        check({name, "_operands_left"}, iss_q.size(), 0);
        check({name, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic check_reset(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_avail_x"}, mcl_avail_x, 0);
        check({name, "_data_x"}, mcl_data_x, 0);
        check({name, "_get"}, mcl_get, 1);
        check({name, "_res_avail"}, res_avail, 0);
        check({name, "_res_data"}, res_data, 0);
        check({name, "_res_idx"}, res_idx, 0);
    endtask

    function automatic logic [W-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int x0, d0, n;
        #1 rst_n = 1'b0;
        tick(3);
        check_reset("reset");
        rst_n = 1'b1;
        tick(2);

        // Basic sweep from 1.0 with unit step.
        start(64'h3FF0_0000_0000_0000, 64'h1, 4, 1'b1);
        wait_done("basic", 200);

        // Consumer backpressure: credits stop issue at FIFO depth.
        res_mode = 1;
        x0 = x_cnt;
        start(rand64(), rand64(), 20, 1'b1);
        tick(40);
        check("bp_issued", x_cnt - x0, DEPTH);
        check("bp_avail_x_low", mcl_avail_x, 0);
        check("bp_res_avail", res_avail, 1);
        res_mode = 0;
        wait_done("bp", 600);

        // Pipeline stalls on alternate cycles.
        get_x_mode = 1;
        start(rand64(), rand64(), 6, 1'b1);
        wait_done("stall", 300);
        get_x_mode = 0;

        // Zero-length sweep.
        x0 = x_cnt;
        d0 = done_cnt;
        start(rand64(), rand64(), 0, 1'b1);
        tick(3);
        check("zero_done_pulses", done_cnt - d0, 1);
        check("zero_issued", x_cnt - x0, 0);
        check("zero_res_avail", res_avail, 0);
        check("zero_busy", busy, 0);

        // A second start while busy must not disturb the running sweep.
        start(64'h4000_0000_0000_0000, 64'h10, 5, 1'b1);
        tick(2);
        cfg_x_start = 64'h1234_5678_9ABC_DEF0;
        cfg_x_step  = 64'h3;
        cfg_count   = CNT_W'(3);
        cfg_start   = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        wait_done("guard", 300);

        // Reset in the middle of a sweep.
        x0 = x_cnt;
        d0 = done_cnt;
        start(rand64(), rand64(), 10, 1'b1);
        n = 0;
        while (x_cnt - x0 < 3 && n < 100) begin
            tick(1);
            n++;
        end
        check("midrst_three_issued", x_cnt - x0 >= 3, 1);
        rst_n = 1'b0;
        tick(1);
        check_reset("midrst");
        exp_q.delete();
        iss_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("midrst_no_done", done_cnt - d0, 0);
        start(64'h3FE0_0000_0000_0000, 64'h100, 2, 1'b1);
        wait_done("post_rst", 200);

        // Random sweeps with random stalls on both sides.
        get_x_mode = 2;
        res_mode   = 2;
        for (int k = 0; k < 6; k++) begin
            start(rand64(), rand64() >> $urandom_range(0, 60), int'($urandom_range(1, 12)), 1'b1);
            wait_done("rand", 2000);
        end
        get_x_mode = 0;
        res_mode   = 0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
